// File: rtl/instr_pkg.sv
// instr_pkg: definitions shared by the instruction encoder and the control decoder.
//   instr_cls_e : request class (R, IALU, LOAD, STORE, BRANCH, JAL; codes 6-7 illegal)
//   OP_*        : RV32I major opcodes (must stay identical to the decoder's values)
//   enc_state_e : encoder session FSM states
//   instr_req_t : one structured instruction request
package instr_pkg;

  typedef enum logic [2:0] {
    CLS_R      = 3'd0,
    CLS_IALU   = 3'd1,
    CLS_LOAD   = 3'd2,
    CLS_STORE  = 3'd3,
    CLS_BRANCH = 3'd4,
    CLS_JAL    = 3'd5
  } instr_cls_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCEPT = 2'd1,
    ST_EMIT   = 2'd2,
    ST_DONE   = 2'd3
  } enc_state_e;

  // cls is kept as raw bits: codes 6-7 must be representable so they can be flagged
  typedef struct packed {
    logic [2:0]  cls;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [20:0] imm;
  } instr_req_t;

endpackage

// File: rtl/instr_field_pack.sv
// instr_field_pack: combinational packer, structured request -> 32-bit RV32I word.
//   req   in  instr_req_t  class + register/funct/immediate fields
//   legal out 1            class is encodable in this build
//   word  out 32           encoded instruction (0 when illegal)
// Config: ENC_JAL_EN defined makes class JAL legal (J-type encoding); otherwise JAL is illegal.
module instr_field_pack
  import instr_pkg::*;
(
  input  instr_req_t  req,
  output logic        legal,
  output logic [31:0] word
);

  logic [20:0] imm;
  assign imm = req.imm;

  // imm[20:13] only feeds the J-type encoding
  logic imm_unused;
  assign imm_unused = ^imm[20:13];

  always_comb begin
    legal = 1'b1;
    word  = '0;
    case (req.cls)
      CLS_R:      word = {req.funct7, req.rs2, req.rs1, req.funct3, req.rd, OP_R};
      CLS_IALU:   word = {imm[11:0], req.rs1, req.funct3, req.rd, OP_IALU};
      CLS_LOAD:   word = {imm[11:0], req.rs1, req.funct3, req.rd, OP_LOAD};
      CLS_STORE:  word = {imm[11:5], req.rs2, req.rs1, req.funct3, imm[4:0], OP_STORE};
      // byte offset: bit 0 is implicit zero and dropped
      CLS_BRANCH: word = {imm[12], imm[10:5], req.rs2, req.rs1, req.funct3,
                          imm[4:1], imm[11], OP_BRANCH};
`ifdef ENC_JAL_EN
      CLS_JAL:    word = {imm[20], imm[10:1], imm[11], imm[19:12], req.rd, OP_JAL};
`endif
      default:    legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: packs structured instruction requests into RV32I words and writes
// them sequentially into instruction memory (IMEM loader for test programs/boot images).
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   start, base_addr   begin a session at base_addr (honoured in IDLE/DONE only)
//   finish             end session (ACCEPT, no request present)
//   req_*              valid/ready request: class, rd/rs1/rs2, funct3, funct7, imm
//   im_we/im_ready     IMEM write handshake; im_addr/im_wdata held until im_ready
//   words_written      words written in this session
//   busy/done/full/err status; err is sticky per session (illegal class seen)
// Config: ENC_JAL_EN enables the JAL class (see instr_field_pack).
module instr_encoder
  import instr_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              finish,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_cls,
  input  logic [4:0]        req_rd,
  input  logic [4:0]        req_rs1,
  input  logic [4:0]        req_rs2,
  input  logic [2:0]        req_funct3,
  input  logic [6:0]        req_funct7,
  input  logic [20:0]       req_imm,
  output logic              im_we,
  input  logic              im_ready,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic [ADDR_W:0]   words_written,
  output logic              busy,
  output logic              done,
  output logic              full,
  output logic              err
);

  localparam logic [ADDR_W:0] LAST = {1'b0, {ADDR_W{1'b1}}};  // capacity - 1

  enc_state_e state, state_nxt;
  instr_req_t req;
  logic        pk_legal;
  logic [31:0] pk_word;

  assign req = '{cls: req_cls, rd: req_rd, rs1: req_rs1, rs2: req_rs2,
                 funct3: req_funct3, funct7: req_funct7, imm: req_imm};

  instr_field_pack u_pack (
    .req   (req),
    .legal (pk_legal),
    .word  (pk_word)
  );

  logic sess_start, take, wr_fire, wr_last;
  assign sess_start = start && (state == ST_IDLE || state == ST_DONE);
  assign take       = (state == ST_ACCEPT) && req_valid;
  assign wr_fire    = (state == ST_EMIT) && im_ready;
  assign wr_last    = words_written == LAST;

  // Status straight from state so an async reset drops im_we in the same instant
  assign req_ready = (state == ST_ACCEPT);
  assign im_we     = (state == ST_EMIT);
  assign busy      = (state == ST_ACCEPT) || (state == ST_EMIT);
  assign done      = (state == ST_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start) state_nxt = ST_ACCEPT;
      ST_ACCEPT: begin
        // a present request wins over finish; caller re-pulses finish later
        if (req_valid) begin
          if (pk_legal) state_nxt = ST_EMIT;
        end else if (finish) begin
          state_nxt = ST_DONE;
        end
      end
      ST_EMIT:   if (im_ready) state_nxt = wr_last ? ST_DONE : ST_ACCEPT;
      ST_DONE:   if (start) state_nxt = ST_ACCEPT;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      im_addr       <= '0;
      im_wdata      <= '0;
      words_written <= '0;
      full          <= 1'b0;
      err           <= 1'b0;
    end else if (sess_start) begin
      im_addr       <= base_addr;
      words_written <= '0;
      full          <= 1'b0;
      err           <= 1'b0;
    end else begin
      if (take) begin
        if (pk_legal) im_wdata <= pk_word;
        else          err      <= 1'b1;
      end
      if (wr_fire) begin
        words_written <= words_written + 1'b1;
        // last slot: address stays on the final word written
        if (wr_last) full    <= 1'b1;
        else         im_addr <= im_addr + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;
  localparam int AW  = 8;
  localparam int CAP = 1 << AW;
`ifdef ENC_JAL_EN
  localparam bit JAL_EN = 1'b1;
`else
  localparam bit JAL_EN = 1'b0;
`endif

  logic          clk = 0, rst_n = 0;
  logic          start = 0, finish = 0, req_valid = 0, im_ready = 0;
  logic [AW-1:0] base_addr = '0;
  logic          req_ready, im_we, busy, done, full, err;
  logic [2:0]    req_cls = '0, req_funct3 = '0;
  logic [4:0]    req_rd = '0, req_rs1 = '0, req_rs2 = '0;
  logic [6:0]    req_funct7 = '0;
  logic [20:0]   req_imm = '0;
  logic [AW-1:0] im_addr;
  logic [31:0]   im_wdata;
  logic [AW:0]   words_written;

  instr_encoder #(.ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .finish(finish),
    .req_valid(req_valid), .req_ready(req_ready), .req_cls(req_cls), .req_rd(req_rd),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_funct3(req_funct3), .req_funct7(req_funct7),
    .req_imm(req_imm), .im_we(im_we), .im_ready(im_ready), .im_addr(im_addr),
    .im_wdata(im_wdata), .words_written(words_written), .busy(busy), .done(done),
    .full(full), .err(err)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  // reference session state
  int m_addr, m_words;
  bit m_err, m_full;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned fld(input int unsigned v, input int hi, input int lo);
    return (v >> lo) & ((32'd1 << (hi - lo + 1)) - 1);
  endfunction

  // Reference encoder, straight from the RV32I format tables
  function automatic bit ref_enc(input int c, input int unsigned rd, input int unsigned rs1,
                                 input int unsigned rs2, input int unsigned f3,
                                 input int unsigned f7, input int unsigned imm,
                                 output logic [31:0] w);
    int unsigned x;
    x = 0;
    case (c)
      0: x = (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 'h33;
      1: x = (fld(imm,11,0) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 'h13;
      2: x = (fld(imm,11,0) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 'h03;
      3: x = (fld(imm,11,5) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
             | (fld(imm,4,0) << 7) | 'h23;
      4: x = (fld(imm,12,12) << 31) | (fld(imm,10,5) << 25) | (rs2 << 20) | (rs1 << 15)
             | (f3 << 12) | (fld(imm,4,1) << 8) | (fld(imm,11,11) << 7) | 'h63;
      5: x = (fld(imm,20,20) << 31) | (fld(imm,10,1) << 21) | (fld(imm,11,11) << 20)
             | (fld(imm,19,12) << 12) | (rd << 7) | 'h6F;
      default: x = 0;
    endcase
    w = x;
    return (c <= 4) || (c == 5 && JAL_EN);
  endfunction

  // Called just after a falling edge with the DUT in ACCEPT.
  // exp_w < 0 means use the reference model for the expected word.
  task automatic do_req(input int c, input int rd, input int rs1, input int rs2, input int f3,
                        input int f7, input int imm, input int stall, input bit fin,
                        input longint exp_w);
    logic [31:0] w;
    bit lg;
    lg = ref_enc(c, rd, rs1, rs2, f3, f7, imm & 'h1FFFFF, w);
    if (exp_w >= 0) w = exp_w[31:0];
    req_valid = 1; req_cls = c[2:0]; req_rd = rd[4:0]; req_rs1 = rs1[4:0];
    req_rs2 = rs2[4:0]; req_funct3 = f3[2:0]; req_funct7 = f7[6:0]; req_imm = imm[20:0];
    finish = fin; im_ready = 0;
    chk("req_ready_pre", req_ready, 1);
    @(posedge clk); @(negedge clk);
    req_valid = 0; finish = 0;
    if (!lg) begin
      m_err = 1;
      chk("ill_err", err, 1);
      chk("ill_we", im_we, 0);
      chk("ill_addr", im_addr, m_addr);
      chk("ill_words", words_written, m_words);
      chk("ill_ready", req_ready, 1);
      return;
    end
    chk("we", im_we, 1);
    chk("addr", im_addr, m_addr);
    chk("wdata", im_wdata, w);
    chk("ready_emit", req_ready, 0);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); @(negedge clk);
      chk("hold_we", im_we, 1);
      chk("hold_addr", im_addr, m_addr);
      chk("hold_wdata", im_wdata, w);
      chk("hold_ready", req_ready, 0);
    end
    im_ready = 1;
    @(posedge clk); @(negedge clk);
    im_ready = 0;
    m_words++;
    if (m_words == CAP) m_full = 1;
    else m_addr = (m_addr + 1) % CAP;
    chk("post_words", words_written, m_words);
    chk("post_addr", im_addr, m_addr);
    chk("post_we", im_we, 0);
    chk("post_full", full, m_full);
    chk("post_done", done, m_full);
    chk("post_ready", req_ready, !m_full);
    chk("post_err", err, m_err);
  endtask

  task automatic start_sess(input int base);
    start = 1; base_addr = base[AW-1:0];
    @(posedge clk); @(negedge clk);
    start = 0;
    m_addr = base; m_words = 0; m_err = 0; m_full = 0;
    chk("st_busy", busy, 1);
    chk("st_ready", req_ready, 1);
    chk("st_addr", im_addr, m_addr);
    chk("st_words", words_written, 0);
    chk("st_err", err, 0);
    chk("st_done", done, 0);
  endtask

  initial begin
    #1;
    chk("rst_ready", req_ready, 0); chk("rst_we", im_we, 0);
    chk("rst_done", done, 0);       chk("rst_full", full, 0);
    chk("rst_err", err, 0);         chk("rst_busy", busy, 0);
    chk("rst_addr", im_addr, 0);    chk("rst_wdata", im_wdata, 0);
    chk("rst_words", words_written, 0);
    @(negedge clk); rst_n = 1;
    @(negedge clk);
    chk("idle_ready", req_ready, 0);

    start_sess('h10);
    do_req(0, 3, 1, 2, 0, 0, 0, 0, 0, 'h002081B3);       // add x3,x1,x2
    do_req(2, 5, 2, 0, 2, 0, 8, 0, 0, 'h00812283);       // lw
    do_req(3, 0, 2, 5, 2, 0, 12, 0, 0, 'h00512623);      // sw
    do_req(4, 0, 1, 2, 0, 0, -4, 0, 0, 'hFE208EE3);      // beq -4
    do_req(1, 7, 3, 0, 0, 0, 'h7FF, 3, 0, -1);           // stalled write
    do_req(7, 1, 1, 1, 0, 0, 0, 0, 0, -1);               // illegal
    do_req(6, 1, 1, 1, 0, 0, 0, 0, 0, -1);               // illegal
    do_req(1, 2, 2, 0, 0, 0, 5, 0, 0, -1);               // normal after error
    do_req(5, 1, 0, 0, 0, 0, 8, 0, 0, JAL_EN ? 'h008000EF : -1);

    // start outside IDLE/DONE is ignored
    start = 1; base_addr = 'h99;
    @(posedge clk); @(negedge clk);
    start = 0;
    chk("start_ign_addr", im_addr, m_addr);
    chk("start_ign_words", words_written, m_words);

    for (int k = 0; k < 40; k++)
      do_req($urandom_range(0, 7), $urandom_range(0, 31), $urandom_range(0, 31),
             $urandom_range(0, 31), $urandom_range(0, 7), $urandom_range(0, 127),
             $urandom_range(0, 'h1FFFFF), $urandom_range(0, 2), 0, -1);

    do_req(0, 1, 2, 3, 4, 5, 0, 0, 1, -1);               // finish shadowed by request
    finish = 1;
    @(posedge clk); @(negedge clk);
    finish = 0;
    chk("fin_done", done, 1); chk("fin_busy", busy, 0);
    chk("fin_ready", req_ready, 0); chk("fin_full", full, 0);

    // fill the whole memory from near the top, wrapping the address
    start_sess('hFD);
    for (int k = 0; k < CAP; k++)
      do_req($urandom_range(0, 4), $urandom_range(0, 31), $urandom_range(0, 31),
             $urandom_range(0, 31), $urandom_range(0, 7), $urandom_range(0, 127),
             $urandom_range(0, 'h1FFFFF), 0, 0, -1);
    chk("full_flag", full, 1); chk("full_done", done, 1);
    chk("full_words", words_written, CAP); chk("full_addr", im_addr, 'hFC);
    chk("full_busy", busy, 0);

    // async reset while a write is pending
    start_sess('h40);
    req_valid = 1; req_cls = 0; im_ready = 0;
    @(posedge clk); @(negedge clk);
    req_valid = 0;
    chk("pre_rst_we", im_we, 1);
    rst_n = 0;
    #1;
    chk("mid_rst_we", im_we, 0);   chk("mid_rst_ready", req_ready, 0);
    chk("mid_rst_busy", busy, 0);  chk("mid_rst_addr", im_addr, 0);
    chk("mid_rst_wdata", im_wdata, 0); chk("mid_rst_words", words_written, 0);
    chk("mid_rst_err", err, 0);
    @(negedge clk); rst_n = 1;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
